div_sequencer: RTL and testbench
================================

DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 Parameter: DIV_LATENCY, 32, cycles from the edge sampling div_start=1 until div_q/div_r are stable.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 in_a  input  WIDTH  dividend.
REQ-008 in_b  input  WIDTH  divisor.
REQ-009 out_valid  output  1  result held and presented.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 out_q / out_r  output  WIDTH each  quotient / remainder.
REQ-012 out_err  output  1  divide-by-zero flag (see Configuration).
REQ-013 div_start  output  1  one-cycle start pulse to the downstream divider.
REQ-014 div_a / div_b  output  WIDTH each  operands to the divider, held stable from the start pulse until the result is captured.
REQ-015 div_q / div_r  input  WIDTH each  divider results.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT, DONE, each with a fixed encoding.
REQ-017 in_ready SHALL be 1 only in IDLE, and is combinational from state only.
REQ-018 IDLE: on an edge with in_valid=1, latch in_a/in_b into div_a/div_b and go to ISSUE. Otherwise stay in IDLE.
REQ-019 ISSUE lasts exactly one cycle with div_start=1. div_start SHALL be 0 in every other state.
REQ-020 On leaving ISSUE, load the wait counter with DIV_LATENCY and go to WAIT.
REQ-021 WAIT decrements the counter each edge. At the edge where the counter equals 0, capture div_q/div_r into out_q/out_r, set out_err=0, and go to DONE.
REQ-022 The result is sampled DIV_LATENCY+1 edges after the edge that samples div_start. out_valid therefore rises DIV_LATENCY+2 cycles after the acceptance edge.
REQ-023 DONE: out_valid=1, and out_q/out_r/out_err are held stable until an edge with out_ready=1. That edge returns the FSM to IDLE.
REQ-024 No new request is accepted in the same cycle the result is consumed. The earliest next acceptance is the edge after the return to IDLE.
REQ-025 in_valid is ignored outside IDLE. in_a/in_b changes after acceptance have no effect.
REQ-026 The counter is log2(DIV_LATENCY+1) bits wide and SHALL never wrap. DIV_LATENCY=0 is legal and gives one WAIT cycle.

Reset
REQ-027 reset=1 at any edge, including mid-WAIT or in DONE, SHALL force IDLE, counter=0, and div_start=0.
REQ-028 The same reset SHALL force out_valid=0, out_q=0, out_r=0, out_err=0, div_a=0, and div_b=0.
REQ-029 reset overrides in_valid and out_ready in the same cycle. No result from an aborted operation is ever presented.

Configuration
REQ-030 With macro DIV_ZERO_CHECK_EN defined, a request with in_b=0 SHALL skip ISSUE and WAIT.
REQ-031 Under DIV_ZERO_CHECK_EN, such a request goes from IDLE directly to DONE with out_q=all-ones, out_r=in_a, out_err=1, and div_start never pulsed. out_valid is high 1 cycle after acceptance.
REQ-032 Without DIV_ZERO_CHECK_EN, in_b=0 is forwarded to the divider like any other value. out_err is tied to 0.

Structure
REQ-033 Package div_seq_pkg SHALL hold the state enum type, the default WIDTH and the default DIV_LATENCY.
REQ-034 One sub-module, div_seq_timer, SHALL contain the loadable down-counter. It has load/enable inputs and a zero flag output.

Verification
REQ-035 Reset, then in_a=100, in_b=7 with L=32 -> div_start pulses 1 cycle after acceptance; out_valid rises 34 cycles after acceptance; out_q=14, out_r=2 (divider model); out_err=0.
REQ-036 Hold out_ready=0 for 10 cycles in DONE -> out_valid, out_q and out_r stay constant; in_ready stays 0; in_valid pulses are ignored.
REQ-037 Assert reset during WAIT (counter=15) -> next cycle is IDLE, out_valid=0, all outputs 0; a new request then completes normally.
REQ-038 Back-to-back requests with out_ready=1 held high -> the second acceptance occurs 2 cycles after the first out_valid rise; there are never two div_start pulses within one operation.
REQ-039 With DIV_ZERO_CHECK_EN, in_a=55, in_b=0 -> out_valid after 1 cycle, out_q=32'hFFFFFFFF, out_r=55, out_err=1, and no div_start. Without the macro, the same stimulus -> normal 34-cycle path and out_err=0.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared types and defaults for the divider sequencer.
package div_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } div_state_e;

  localparam int unsigned DEF_WIDTH       = 32;
  localparam int unsigned DEF_DIV_LATENCY = 32;

endpackage

// File: rtl/div_seq_timer.sv
// Loadable down-counter that saturates at zero; zero flag is a pure decode of the count.
module div_seq_timer #(
  parameter int unsigned CW = 6
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/div_sequencer.sv
// Request/response wrapper around a fixed-latency external divider.
// Optional macro DIV_ZERO_CHECK_EN: divide-by-zero requests bypass the divider and flag out_err.
module div_sequencer
  import div_seq_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned DIV_LATENCY = DEF_DIV_LATENCY
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic             out_err,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r
);

  localparam int unsigned   CW       = (DIV_LATENCY == 0) ? 1 : $clog2(DIV_LATENCY + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(DIV_LATENCY);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] div_b_q, div_b_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             tmr_load, tmr_en, tmr_zero;
`ifdef DIV_ZERO_CHECK_EN
  logic             err_q, err_d;
`endif

  div_seq_timer #(
    .CW (CW)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (LOAD_VAL),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    div_a_d  = div_a_q;
    div_b_d  = div_b_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          div_a_d = in_a;
          div_b_d = in_b;
          state_d = ISSUE;
`ifdef DIV_ZERO_CHECK_EN
          if (in_b == '0) begin
            quo_d   = '1;
            rem_d   = in_a;
            err_d   = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      ISSUE: begin
        tmr_load = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (tmr_zero) begin
          quo_d   = div_q;
          rem_d   = div_r;
`ifdef DIV_ZERO_CHECK_EN
          err_d   = 1'b0;
`endif
          state_d = DONE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      div_a_q <= '0;
      div_b_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef DIV_ZERO_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef DIV_ZERO_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign div_start = (state_q == ISSUE);
  assign out_valid = (state_q == DONE);
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign out_q     = quo_q;
  assign out_r     = rem_q;
`ifdef DIV_ZERO_CHECK_EN
  assign out_err   = err_q;
`else
  assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer with a fixed-latency behavioural divider.
module tb_div_sequencer;

  localparam int unsigned W = 32;
  localparam int unsigned L = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         err;
    int           lat;
    int           starts;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset, in_valid, out_ready;
  logic [W-1:0] in_a, in_b;
  logic         in_ready, out_valid, out_err, div_start;
  logic [W-1:0] out_q, out_r, div_a, div_b;
  logic [W-1:0] div_q = '0;
  logic [W-1:0] div_r = '0;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t cur;
  logic [W-1:0] exp_a, exp_b;
  int   acc_cyc = 0, rise_cyc = 0, starts = 0, stim_acc = 0;
  bit   gap_check = 1'b0;
  bit   prev_valid = 1'b0, prev_ready = 1'b0;
  int   dcnt = 0;

  div_sequencer #(
    .WIDTH       (W),
    .DIV_LATENCY (L)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .out_err   (out_err),
    .div_start (div_start),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_q     (div_q),
    .div_r     (div_r)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Divider model: junk until L edges after the start edge, so an early capture is visible.
  always @(posedge clock) begin
    if (div_start) begin
      dcnt  <= 1;
      div_q <= 32'hDEADBEEF;
      div_r <= 32'hBADC0DE5;
    end else if (dcnt != 0) begin
      if (dcnt == L) begin
        div_q <= (div_b == '0) ? '1 : div_a / div_b;
        div_r <= (div_b == '0) ? div_a : div_a % div_b;
        dcnt  <= 0;
      end else begin
        dcnt <= dcnt + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Monitor: sampled between negedge and posedge, well clear of the active edge.
  always begin
    @(negedge clock);
    #2;
    if (reset) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (div_start) begin
        starts++;
        check("start_time", 64'(cyc - acc_cyc), 64'd0);
        check("div_a", 64'(div_a), 64'(exp_a));
        check("div_b", 64'(div_b), 64'(exp_b));
      end
      if (prev_valid && !prev_ready) check("hold_valid", 64'(out_valid), 64'd1);
      if (prev_valid && prev_ready)  check("release", 64'(out_valid), 64'd0);
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got q=%0h r=%0h required no output", out_q, out_r);
        end else begin
          cur = sb.pop_front();
          rise_cyc = cyc;
          check("latency", 64'(cyc - acc_cyc), 64'(cur.lat));
          check("out_q", 64'(out_q), 64'(cur.q));
          check("out_r", 64'(out_r), 64'(cur.r));
          check("out_err", 64'(out_err), 64'(cur.err));
          check("start_count", 64'(starts), 64'(cur.starts));
        end
      end else if (out_valid) begin
        check("hold_q", 64'(out_q), 64'(cur.q));
        check("hold_r", 64'(out_r), 64'(cur.r));
        check("hold_err", 64'(out_err), 64'(cur.err));
      end
      if (in_valid && in_ready) begin
        acc_cyc = cyc + 1;
        starts  = 0;
        if (gap_check) check("b2b_gap", 64'(acc_cyc - rise_cyc), 64'd2);
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push, input exp_t e);
    int n = 0;
    @(negedge clock);
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) timeout("issue_wait");
    exp_a    = a;
    exp_b    = b;
    if (push) sb.push_back(e);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    stim_acc = cyc + 1;
    @(negedge clock);
    in_valid = 1'b0;
    in_a     = 32'h5A5A_1234;
    in_b     = 32'h0000_0003;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0 || out_valid) timeout("wait_idle");
    @(negedge clock);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_div_start"}, 64'(div_start), 64'd0);
    check({tag, "_out_q"}, 64'(out_q), 64'd0);
    check({tag, "_out_r"}, 64'(out_r), 64'd0);
    check({tag, "_out_err"}, 64'(out_err), 64'd0);
    check({tag, "_div_a"}, 64'(div_a), 64'd0);
    check({tag, "_div_b"}, 64'(div_b), 64'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_a      = '0;
    in_b      = '0;
    repeat (3) @(negedge clock);
    check_cleared("reset");
    reset = 1'b0;

    // Hold the result in DONE for 10 cycles while in_valid pulses are ignored.
    out_ready = 1'b0;
    issue(32'd100, 32'd7, 1'b1, exp_t'{32'd14, 32'd2, 1'b0, 34, 1});
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!out_valid) timeout("first_valid");
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      in_valid = ~in_valid;
      in_a     = 32'(i + 1000);
      in_b     = 32'(i + 1);
    end
    out_ready = 1'b1;
    wait_idle();

    // Reset while the wait counter holds 15; the aborted result must never appear.
    issue(32'd1000, 32'd10, 1'b0, exp_t'{32'd0, 32'd0, 1'b0, 0, 0});
    while (cyc < stim_acc + 18) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_cleared("abort");
    issue(32'd1000, 32'd10, 1'b1, exp_t'{32'd100, 32'd0, 1'b0, 34, 1});
    wait_idle();

    // Back-to-back with out_ready held high.
    issue(32'd5, 32'd9, 1'b1, exp_t'{32'd0, 32'd5, 1'b0, 34, 1});
    gap_check = 1'b1;
    issue(32'hFFFF_FFFF, 32'd1, 1'b1, exp_t'{32'hFFFF_FFFF, 32'd0, 1'b0, 34, 1});
    issue(32'd7, 32'd7, 1'b1, exp_t'{32'd1, 32'd0, 1'b0, 34, 1});
    wait_idle();
    gap_check = 1'b0;

    // Divide by zero.
`ifdef DIV_ZERO_CHECK_EN
    e = exp_t'{32'hFFFF_FFFF, 32'd55, 1'b1, 0, 0};
`else
    e = exp_t'{32'hFFFF_FFFF, 32'd55, 1'b0, 34, 1};
`endif
    issue(32'd55, 32'd0, 1'b1, e);
    wait_idle();
    repeat (5) @(negedge clock);
    check("final_idle", 64'(in_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
